cache_refill_unit: RTL
======================

# cache_refill_unit

Line-refill engine for the cache data array. On a miss it issues one line-aligned burst read to the next memory level, streams the returned beats into the data RAM's write port one word per beat, and forwards the critical (missed) word the cycle it is written. It sits directly upstream of the data RAM, driving its write enable, write address and write data, and signals line completion to the cache controller.

## Interface
- DATA_WIDTH, 32, word width; byte offset bits BO = log2(DATA_WIDTH/8) = 2
- ADDR_WIDTH, 32, byte address width
- LINE_WORDS, 8, words per line (power of two); OFF = log2(LINE_WORDS) = 3
- INDEX_WIDTH, 6, set-index bits; data RAM address width = INDEX_WIDTH+OFF = 9
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- MISS_VALID  in  1  miss request valid
- MISS_READY  out  1  unit can accept a miss (high only in IDLE)
- MISS_ADDR  in  ADDR_WIDTH  byte address of missing word
- MEM_ARVALID / MEM_ARREADY  out / in  1  burst request handshake
- MEM_ARADDR  out  ADDR_WIDTH  line-aligned address (low BO+OFF bits zero)
- MEM_RVALID / MEM_RREADY  in / out  1  read-beat handshake
- MEM_RDATA  in  DATA_WIDTH  beat data; MEM_RLAST  in  1  final beat marker
- DMEM_WREN  out  1  data RAM write enable
- DMEM_WADDR  out  INDEX_WIDTH+OFF  {index, word offset}
- DMEM_DATA_IN  out  DATA_WIDTH  data RAM write data
- CRIT_VALID  out  1  pulse: critical word on CRIT_DATA
- CRIT_DATA  out  DATA_WIDTH  critical word
- REFILL_DONE  out  1  one-cycle pulse: line fully written
- REFILL_ERR  out  1  qualifies REFILL_DONE: burst length was not LINE_WORDS

## Operation
- States: IDLE -> REQ -> FILL -> DONE -> IDLE.
- IDLE: MISS_READY=1. On MISS_VALID&MISS_READY latch MISS_ADDR, clear beat counter (OFF+1 bits), go REQ.
- REQ: MEM_ARVALID=1, MEM_ARADDR = latched address with low BO+OFF bits cleared, held stable until MEM_ARREADY; on handshake go FILL.
- FILL: MEM_RREADY=1. Each beat (MEM_RVALID&MEM_RREADY) with counter < LINE_WORDS registers a write: DMEM_WADDR={MISS_ADDR[BO+OFF +: INDEX_WIDTH], counter[OFF-1:0]}, DMEM_DATA_IN=MEM_RDATA. Counter increments every beat; beats beyond LINE_WORDS are accepted and dropped (no write). Beats arrive in order from word 0 (incrementing, no wrap).
- Critical word: write whose offset equals MISS_ADDR[BO +: OFF] also drives CRIT_VALID=1, CRIT_DATA=that data, same cycle as its DMEM_WREN.
- Beat with MEM_RLAST ends FILL -> DONE. REFILL_ERR=1 if total beats (including the RLAST beat) != LINE_WORDS.
- DONE: REFILL_DONE=1 (and REFILL_ERR as computed) for one cycle, then IDLE.
- MEM_RVALID outside FILL is ignored (RREADY=0).

## Timing
- Reset values: state IDLE, MISS_READY=1, MEM_ARVALID=0, MEM_ARADDR=0, MEM_RREADY=0, DMEM_WREN=0, DMEM_WADDR=0, DMEM_DATA_IN=0, CRIT_VALID=0, CRIT_DATA=0, REFILL_DONE=0, REFILL_ERR=0.
- MISS_READY, MEM_ARVALID, MEM_RREADY combinational from state; DMEM_*, CRIT_*, REFILL_* registered.
- Beat accepted at edge N -> DMEM_WREN high during cycle N..N+1; RAM captures at edge N+1.
- Last beat at edge N -> REFILL_DONE high during cycle N+1..N+2; line readable in RAM from that cycle.
- Miss accepted at edge M -> MEM_ARVALID earliest high in cycle M..M+1. Minimum miss-to-done for 8 back-to-back beats with ARREADY=1: 11 cycles.
- Back-to-back misses: next MISS_READY=1 the cycle after REFILL_DONE.
- RST asserted mid-REQ/FILL: immediate return to IDLE, partial line abandoned, no REFILL_DONE; next-level memory shares RST.

## Structure
- Shared package cache_pkg: BO, OFF, INDEX_WIDTH, LINE_WORDS localparams, state enum (IDLE, REQ, FILL, DONE).
- Single module, no sub-module; counter and FSM inline.

## Test plan
- Miss 0x0000_0124, ARREADY=1, 8 beats 0xA0..0xA7 no gaps -> ARADDR 0x120, DMEM_WADDR 0x48..0x4F, CRIT_DATA=0xA1, REFILL_DONE at cycle 11, ERR=0.
- Same miss, ARREADY delayed 3 cycles, RVALID toggling every other cycle -> ARADDR stable throughout, 8 writes in order, no write on idle cycles.
- RLAST on beat 5 -> 5 writes, REFILL_DONE=1, REFILL_ERR=1.
- 10 beats, RLAST on beat 10 -> only 8 writes, REFILL_ERR=1.
- RST pulsed after beat 3 -> outputs at reset values, no REFILL_DONE, MISS_READY=1, new miss completes normally.
- Two misses queued on MISS_VALID -> second accepted the cycle after first REFILL_DONE.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache refill constants and FSM state type
package cache_pkg;

    localparam int LINE_WORDS  = 8;
    localparam int INDEX_WIDTH = 6;
    localparam int BO          = 2;
    localparam int OFF         = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } refill_state_e;

endpackage

// File: rtl/cache_refill_unit.sv
// rtl/cache_refill_unit.sv - line refill engine: burst read, data RAM write, critical word forward
module cache_refill_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WORDS  = cache_pkg::LINE_WORDS,
    parameter int INDEX_WIDTH = cache_pkg::INDEX_WIDTH
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic                                      MISS_VALID,
    output logic                                      MISS_READY,
    input  logic [ADDR_WIDTH-1:0]                     MISS_ADDR,
    output logic                                      MEM_ARVALID,
    input  logic                                      MEM_ARREADY,
    output logic [ADDR_WIDTH-1:0]                     MEM_ARADDR,
    input  logic                                      MEM_RVALID,
    output logic                                      MEM_RREADY,
    input  logic [DATA_WIDTH-1:0]                     MEM_RDATA,
    input  logic                                      MEM_RLAST,
    output logic                                      DMEM_WREN,
    output logic [INDEX_WIDTH+$clog2(LINE_WORDS)-1:0] DMEM_WADDR,
    output logic [DATA_WIDTH-1:0]                     DMEM_DATA_IN,
    output logic                                      CRIT_VALID,
    output logic [DATA_WIDTH-1:0]                     CRIT_DATA,
    output logic                                      REFILL_DONE,
    output logic                                      REFILL_ERR
);
    import cache_pkg::*;

    localparam int BO_W  = $clog2(DATA_WIDTH / 8);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int CNT_W = OFF_W + 1;
    localparam int WA_W  = INDEX_WIDTH + OFF_W;

    // Clears the byte and word offset so the burst starts at word 0 of the line
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((LINE_WORDS * DATA_WIDTH / 8) - 1);
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(LINE_WORDS - 1);

    refill_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [OFF_W-1:0]      crit_off_q, crit_off_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  len_err_q, len_err_d;
    logic                  dmem_wren_q, dmem_wren_d;
    logic [WA_W-1:0]       dmem_waddr_q, dmem_waddr_d;
    logic [DATA_WIDTH-1:0] dmem_data_q, dmem_data_d;
    logic                  crit_valid_q, crit_valid_d;
    logic [DATA_WIDTH-1:0] crit_data_q, crit_data_d;
    logic                  refill_done_q, refill_done_d;
    logic                  refill_err_q, refill_err_d;

    logic miss_fire;
    logic beat_fire;

    assign miss_fire = MISS_VALID && MISS_READY;
    assign beat_fire = MEM_RVALID && MEM_RREADY;

    // State register; reset abandons any partial line
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: DONE lasts two cycles so MISS_READY only returns after the done pulse
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (MISS_VALID)               state_d = REQ;
            REQ:  if (MEM_ARREADY)              state_d = FILL;
            FILL: if (MEM_RVALID && MEM_RLAST)  state_d = DONE;
            DONE: if (refill_done_q)            state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state
    always_comb begin
        MISS_READY  = (state_q == IDLE);
        MEM_ARVALID = (state_q == REQ);
        MEM_RREADY  = (state_q == FILL);
    end

    // Miss capture, beat counting and next values of the registered outputs
    always_comb begin
        line_addr_d   = line_addr_q;
        crit_off_d    = crit_off_q;
        beat_cnt_d    = beat_cnt_q;
        len_err_d     = len_err_q;
        dmem_wren_d   = 1'b0;
        dmem_waddr_d  = dmem_waddr_q;
        dmem_data_d   = dmem_data_q;
        crit_valid_d  = 1'b0;
        crit_data_d   = crit_data_q;
        refill_done_d = (state_q == DONE) && !refill_done_q;
        refill_err_d  = (state_q == DONE) && !refill_done_q && len_err_q;

        if (miss_fire) begin
            line_addr_d = MISS_ADDR & LINE_MASK;
            crit_off_d  = MISS_ADDR[BO_W +: OFF_W];
            beat_cnt_d  = '0;
            len_err_d   = 1'b0;
        end

        if (beat_fire) begin
            // The counter holds at LINE_WORDS so an over-long burst never wraps into new writes
            if (beat_cnt_q < CNT_FULL) begin
                dmem_wren_d  = 1'b1;
                dmem_waddr_d = {line_addr_q[BO_W+OFF_W +: INDEX_WIDTH], beat_cnt_q[OFF_W-1:0]};
                dmem_data_d  = MEM_RDATA;
                beat_cnt_d   = beat_cnt_q + CNT_W'(1);
                if (beat_cnt_q[OFF_W-1:0] == crit_off_q) begin
                    crit_valid_d = 1'b1;
                    crit_data_d  = MEM_RDATA;
                end
            end
            // Exactly LINE_WORDS beats means the last one arrives with the count at LINE_WORDS-1
            if (MEM_RLAST) begin
                len_err_d = (beat_cnt_q != CNT_LAST);
            end
        end
    end

    // Datapath and registered output flops
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            line_addr_q   <= '0;
            crit_off_q    <= '0;
            beat_cnt_q    <= '0;
            len_err_q     <= 1'b0;
            dmem_wren_q   <= 1'b0;
            dmem_waddr_q  <= '0;
            dmem_data_q   <= '0;
            crit_valid_q  <= 1'b0;
            crit_data_q   <= '0;
            refill_done_q <= 1'b0;
            refill_err_q  <= 1'b0;
        end else begin
            line_addr_q   <= line_addr_d;
            crit_off_q    <= crit_off_d;
            beat_cnt_q    <= beat_cnt_d;
            len_err_q     <= len_err_d;
            dmem_wren_q   <= dmem_wren_d;
            dmem_waddr_q  <= dmem_waddr_d;
            dmem_data_q   <= dmem_data_d;
            crit_valid_q  <= crit_valid_d;
            crit_data_q   <= crit_data_d;
            refill_done_q <= refill_done_d;
            refill_err_q  <= refill_err_d;
        end
    end

    assign MEM_ARADDR   = line_addr_q;
    assign DMEM_WREN    = dmem_wren_q;
    assign DMEM_WADDR   = dmem_waddr_q;
    assign DMEM_DATA_IN = dmem_data_q;
    assign CRIT_VALID   = crit_valid_q;
    assign CRIT_DATA    = crit_data_q;
    assign REFILL_DONE  = refill_done_q;
    assign REFILL_ERR   = refill_err_q;

endmodule
